output_port_arbiter: RTL and testbench
======================================

OUTPUT_PORT_ARBITER -- requirements
Module: output_port_arbiter

Interface
REQ-001 SHALL have parameter flit_size, default 16, meaning payload flit width.
REQ-002 SHALL have parameter modified_flit_size, default flit_size+2, meaning the routed flit width {route[1:0], flit}.
REQ-003 SHALL have parameter port_id, default 2'd0, meaning the output port this instance serves.
REQ-004 SHALL have port clk, input, 1, meaning the single clock; all state on rising edge.
REQ-005 SHALL have port reset, input, 1, meaning asynchronous active-high reset.
REQ-006 SHALL have port in_flits, input, 4*modified_flit_size, meaning the routed flits from input ports 0..3, with port i at slice [i*modified_flit_size +: modified_flit_size].
REQ-007 SHALL have port in_valid, input, 4, meaning per-input flit present.
REQ-008 SHALL have port in_ready, output, 4, meaning per-input flit accepted this cycle.
REQ-009 SHALL have port out_flit, output, flit_size, meaning the granted flit with the route field stripped.
REQ-010 SHALL have port out_valid, output, 1, meaning out_flit holds a flit.
REQ-011 SHALL have port out_ready, input, 1, meaning the downstream stage accepts out_flit.

Function
REQ-012 Request: req[i] SHALL be in_valid[i] and route field (bits [modified_flit_size-1 -: 2]) equal to port_id.
REQ-013 load_en SHALL be !out_valid or out_ready.
REQ-014 Arbitration SHALL be round-robin over req, searching upward (modulo 4) from pointer rr_ptr[1:0].
REQ-015 in_ready SHALL be one-hot of the winner when load_en and any req; otherwise all zeros; a non-requesting input never sees in_ready high.
REQ-016 On load: out_flit SHALL capture the winner's flit[flit_size-1:0], out_valid SHALL be set, and rr_ptr SHALL become winner+1 (wrap 3->0).
REQ-017 Latency SHALL be 1 cycle, from the in_valid/in_ready handshake to out_valid.
REQ-018 Throughput SHALL be one flit per cycle: drain (out_valid and out_ready) and load in the same cycle SHALL replace the register with no bubble.
REQ-019 Stall (out_valid and !out_ready): out_flit, out_valid and rr_ptr SHALL hold, and in_ready SHALL be 0.
REQ-020 Drain with no req: out_valid SHALL clear next cycle, and out_flit SHALL hold its last value.
REQ-021 No req while empty: state SHALL be unchanged.
REQ-022 Flits routed to other ports SHALL never be accepted or reordered.

Reset
REQ-023 Reset SHALL be asynchronous and active-high.
REQ-024 Reset SHALL set out_valid=0, out_flit=0 and rr_ptr=0, so input 0 has first priority.
REQ-025 in_ready SHALL be 0 while reset is asserted.
REQ-026 Reset mid-stall SHALL discard the held flit, with no output handshake.
REQ-027 After reset deasserts, arbitration SHALL resume on the next rising edge.

Structure
REQ-028 Shared package noc_pkg SHALL hold FLIT_SIZE, ROUTE_BITS=2, and port encodings NORTH=0, EAST=1, SOUTH=2, WEST=3.
REQ-029 One sub-module, rr_arbiter_4, SHALL implement the combinational 4-way round-robin grant from req and rr_ptr.
REQ-030 The pointer register and output register SHALL reside in output_port_arbiter.

Verification
REQ-031 Reset, then in 0 valid with route=port_id and flit 16'hA5A5 -> in_ready=4'b0001 that cycle; next cycle out_valid=1, out_flit=16'hA5A5.
REQ-032 All four inputs requesting, out_ready=1 held -> grants in order 0,1,2,3,0, one per cycle, with out_valid continuously 1.
REQ-033 in 2 valid but route!=port_id -> in_ready stays 0 and out_valid stays 0 for 10 cycles.
REQ-034 out_ready=0 for 5 cycles with out_valid=1 and inputs 1,3 requesting -> out_flit stable, in_ready=0 throughout; after release, input 1 is granted first, then 3.
REQ-035 reset asserted mid-stall -> out_valid=0 and out_flit=0 immediately (asynchronously); after release, rr_ptr=0 gives input 0 first grant.
REQ-036 Single requester toggling every other cycle, out_ready=1 -> out_valid pulses 1,0,1,0 with 1-cycle latency, and no duplicated flits.

Source files
------------

// File: rtl/noc_pkg.sv
// noc_pkg: shared flit geometry and output-port encodings for the router
package noc_pkg;
  localparam int FLIT_SIZE = 16;
  localparam int ROUTE_BITS = 2;
  typedef enum logic [1:0] {NORTH = 2'd0, EAST = 2'd1, SOUTH = 2'd2, WEST = 2'd3} port_e;
endpackage

// File: rtl/rr_arbiter_4.sv
// rr_arbiter_4: combinational 4-way round-robin grant, searching upward from ptr_i
module rr_arbiter_4 (
  input  logic [3:0] req_i,
  input  logic [1:0] ptr_i,
  output logic [3:0] grant_o,
  output logic [1:0] winner_o,
  output logic       any_o
);
  always_comb begin
    winner_o = ptr_i;
    any_o = |req_i;
    // Descending offsets so the nearest requester at or above ptr_i is written last.
    for (int k = 3; k >= 0; k--)
      if (req_i[ptr_i + 2'(k)]) winner_o = ptr_i + 2'(k);
    grant_o = any_o ? 4'b0001 << winner_o : 4'b0000;
  end
endmodule

// File: rtl/output_port_arbiter.sv
// output_port_arbiter: round-robin selects one routed flit per cycle from 4 inputs
// into a single registered output stage, stripping the route field.
module output_port_arbiter
  import noc_pkg::*;
#(
  parameter int          flit_size          = FLIT_SIZE,
  parameter int          modified_flit_size = flit_size + ROUTE_BITS,
  parameter logic [1:0]  port_id            = 2'd0
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [4*modified_flit_size-1:0] in_flits,
  input  logic [3:0]                      in_valid,
  output logic [3:0]                      in_ready,
  output logic [flit_size-1:0]            out_flit,
  output logic                            out_valid,
  input  logic                            out_ready
);
  logic [3:0] req, grant;
  logic [1:0] winner, rr_ptr_q, rr_ptr_d;
  logic any_req, load_en, take;
  logic [flit_size-1:0] out_flit_q, out_flit_d;
  logic out_valid_q, out_valid_d;
  always_comb begin
    req = '0;
    for (int i = 0; i < 4; i++)
      req[i] = in_valid[i] && (in_flits[i*modified_flit_size + modified_flit_size - 1 -: ROUTE_BITS] == port_id);
  end
  rr_arbiter_4 u_rr (
    .req_i   (req),
    .ptr_i   (rr_ptr_q),
    .grant_o (grant),
    .winner_o(winner),
    .any_o   (any_req)
  );
  always_comb begin
    load_en = !out_valid_q || out_ready;
    take = load_en && any_req;
    out_flit_d = take ? in_flits[int'(winner)*modified_flit_size +: flit_size] : out_flit_q;
    out_valid_d = take || (out_valid_q && !out_ready);
    rr_ptr_d = take ? winner + 2'd1 : rr_ptr_q;
    in_ready = (take && !reset) ? grant : 4'b0000;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_flit_q <= '0;
      out_valid_q <= 1'b0;
      rr_ptr_q <= 2'd0;
    end else begin
      out_flit_q <= out_flit_d;
      out_valid_q <= out_valid_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end
  assign out_flit = out_flit_q;
  assign out_valid = out_valid_q;
endmodule

// File: tb/tb_output_port_arbiter.sv
// tb_output_port_arbiter: directed stimulus with a queue scoreboard of expected output flits
module tb_output_port_arbiter;
  import noc_pkg::*;
  localparam int FW = 16;
  localparam int MW = 18;
  localparam logic [1:0] PID = SOUTH;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [4*MW-1:0] in_flits;
  logic [3:0] in_valid, in_ready;
  logic [FW-1:0] out_flit;
  logic out_valid, out_ready;
  int checks = 0;
  int failures = 0;
  int seq = 1;
  logic [FW-1:0] q[$];
  logic [FW-1:0] last_exp;
  output_port_arbiter #(.flit_size(FW), .modified_flit_size(MW), .port_id(PID)) dut (
    .clk(clk), .reset(reset), .in_flits(in_flits), .in_valid(in_valid), .in_ready(in_ready),
    .out_flit(out_flit), .out_valid(out_valid), .out_ready(out_ready)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask
  task automatic set_flits(input logic [3:0] to_me, input logic [FW-1:0] b);
    for (int i = 0; i < 4; i++)
      in_flits[i*MW +: MW] = {to_me[i] ? PID : (PID ^ 2'd1), b + FW'(i)};
  endtask
  // One cycle: drive inputs, expect a grant (idx) and optionally out_valid / out_flit.
  task automatic step(input logic [3:0] v, input logic [3:0] to_me, input logic ordy,
                      input logic [3:0] exp_rdy, input int idx, input int base,
                      input int ov, input int of, input string name);
    logic [FW-1:0] b;
    @(posedge clk);
    #1;
    b = (base < 0) ? {seq[11:0], 4'h0} : FW'(base);
    seq++;
    in_valid = v;
    out_ready = ordy;
    set_flits(to_me, b);
    if (idx >= 0) begin
      last_exp = b + FW'(idx);
      q.push_back(last_exp);
    end
    @(negedge clk);
    chk({name, " in_ready"}, 32'(in_ready), 32'(exp_rdy));
    if (ov >= 0) chk({name, " out_valid"}, 32'(out_valid), ov);
    if (of >= 0) chk({name, " out_flit"}, 32'(out_flit), of);
  endtask
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL monitor unexpected flit actual=%0h required=none", out_flit);
      end else chk("monitor flit", 32'(out_flit), 32'(q.pop_front()));
    end
  end
  initial begin
    in_valid = '0;
    in_flits = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    in_valid = 4'b1111;
    set_flits(4'b1111, 16'h1000);
    #1;
    chk("reset in_ready", 32'(in_ready), 0);
    chk("reset out_valid", 32'(out_valid), 0);
    chk("reset out_flit", 32'(out_flit), 0);
    in_valid = '0;
    @(negedge clk) reset = 1'b0;
    step(4'b0001, 4'b0001, 1, 4'b0001, 0, 16'hA5A5, 0, -1, "a_load");
    step(4'b0000, 4'b0000, 1, 4'b0000, -1, -1, 1, int'(last_exp), "a_out");
    step(4'b0000, 4'b0000, 1, 4'b0000, -1, -1, 0, 16'hA5A5, "a_drain_hold");
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk) reset = 1'b0;
    step(4'b1111, 4'b1111, 1, 4'b0001, 0, -1, 0, -1, "b_rr0");
    step(4'b1111, 4'b1111, 1, 4'b0010, 1, -1, 1, -1, "b_rr1");
    step(4'b1111, 4'b1111, 1, 4'b0100, 2, -1, 1, -1, "b_rr2");
    step(4'b1111, 4'b1111, 1, 4'b1000, 3, -1, 1, -1, "b_rr3");
    step(4'b1111, 4'b1111, 1, 4'b0001, 0, -1, 1, -1, "b_rr4");
    step(4'b0000, 4'b0000, 1, 4'b0000, -1, -1, 1, -1, "b_last");
    for (int n = 0; n < 10; n++)
      step(4'b0100, 4'b0000, 1, 4'b0000, -1, -1, 0, -1, "c_other_route");
    step(4'b0001, 4'b0001, 1, 4'b0001, 0, -1, 0, -1, "d_load");
    for (int n = 0; n < 5; n++)
      step(4'b1010, 4'b1010, 0, 4'b0000, -1, -1, 1, int'(last_exp), "d_stall");
    step(4'b1010, 4'b1010, 1, 4'b0010, 1, -1, 1, -1, "d_rel1");
    step(4'b1000, 4'b1000, 1, 4'b1000, 3, -1, 1, -1, "d_rel3");
    step(4'b0000, 4'b0000, 1, 4'b0000, -1, -1, 1, -1, "d_drain");
    step(4'b0000, 4'b0000, 1, 4'b0000, -1, -1, 0, -1, "d_empty");
    step(4'b0010, 4'b0010, 1, 4'b0010, 1, -1, 0, -1, "e_load");
    step(4'b0000, 4'b0000, 0, 4'b0000, -1, -1, 1, int'(last_exp), "e_stall");
    @(posedge clk);
    #2 reset = 1'b1;
    in_valid = 4'b1111;
    set_flits(4'b1111, 16'h2000);
    #1;
    chk("e_async out_valid", 32'(out_valid), 0);
    chk("e_async out_flit", 32'(out_flit), 0);
    chk("e_async in_ready", 32'(in_ready), 0);
    q.delete();
    in_valid = '0;
    @(negedge clk) reset = 1'b0;
    step(4'b1111, 4'b1111, 1, 4'b0001, 0, -1, 0, -1, "e_first");
    step(4'b0000, 4'b0000, 1, 4'b0000, -1, -1, 1, int'(last_exp), "e_out");
    step(4'b0000, 4'b0000, 1, 4'b0000, -1, -1, 0, -1, "e_empty");
    for (int n = 0; n < 3; n++) begin
      step(4'b1000, 4'b1000, 1, 4'b1000, 3, -1, 0, -1, "f_req");
      step(4'b0000, 4'b0000, 1, 4'b0000, -1, -1, 1, int'(last_exp), "f_pulse");
    end
    step(4'b0000, 4'b0000, 1, 4'b0000, -1, -1, 0, -1, "f_end");
    chk("queue empty", 32'(q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
